// File: rtl/mem_access_pkg.sv
// Shared types and default widths for the memory access controller and the
// dual-port data RAM that sits beside it.
package mem_access_pkg;

    // Controller sequencing: idle/store, wait for RAM read latency, hold response.
    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_RESP} mac_state_t;

    localparam int unsigned DEFAULT_DATA_WIDTH    = 16;
    localparam int unsigned DEFAULT_ADDRESS_WIDTH = 8;
    localparam int unsigned DEFAULT_COUNT_WIDTH   = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low clear; stops at all-ones.
module sat_counter #(
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   clear_n,
    input  logic                   inc,
    output logic [COUNT_WIDTH-1:0] count
);

    logic [COUNT_WIDTH-1:0] count_q;

    // Increment on request unless already pinned at all-ones.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            count_q <= '0;
        end else if (inc && (count_q != {COUNT_WIDTH{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store requester for a dual-port RAM with a 1-cycle registered read port.
// Stores go straight to the write port in the accept cycle; loads wait out the
// read latency and are returned over a valid/ready response channel.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int unsigned COUNT_WIDTH   = DEFAULT_COUNT_WIDTH
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [ADDRESS_WIDTH-1:0] req_address,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic [ADDRESS_WIDTH-1:0] ram_write_address,
    output logic                     ram_write_enable,
    output logic [DATA_WIDTH-1:0]    ram_write_data,
    output logic [ADDRESS_WIDTH-1:0] ram_read_address,
    output logic                     ram_read_enable,
    input  logic [DATA_WIDTH-1:0]    ram_read_data,
    output logic [COUNT_WIDTH-1:0]   store_count,
    output logic [COUNT_WIDTH-1:0]   load_count
);

    mac_state_t            state_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  accept;
    logic                  store_inc;
    logic                  load_inc;

    // Ready is gated by reset_n so nothing is accepted while reset is held.
    always_comb begin
        req_ready = reset_n && (state_q == IDLE);
        accept    = req_valid && req_ready;
    end

    // RAM ports follow the request directly; only the enables are qualified.
    always_comb begin
        ram_write_address = req_address;
        ram_write_data    = req_wdata;
        ram_write_enable  = accept && req_write;
        ram_read_address  = req_address;
        ram_read_enable   = accept && !req_write;
        store_inc         = ram_write_enable;
        load_inc          = (state_q == RD_RESP) && rsp_ready;
    end

    // Sequencer: absorb read latency, capture read data, hold it until taken.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept && !req_write) begin
                        state_q <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    rsp_rdata_q <= ram_read_data;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RD_RESP;
                end
                RD_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

    sat_counter #(
        .COUNT_WIDTH(COUNT_WIDTH)
    ) u_store_counter (
        .clock  (clock),
        .clear_n(reset_n),
        .inc    (store_inc),
        .count  (store_count)
    );

    sat_counter #(
        .COUNT_WIDTH(COUNT_WIDTH)
    ) u_load_counter (
        .clock  (clock),
        .clear_n(reset_n),
        .inc    (load_inc),
        .count  (load_count)
    );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: behavioural RAM beside the controller, a second
// controller instance with 4-bit counters sharing the same stimulus, and an
// array/integer reference model of memory contents and activity counts.
module tb_mem_access_ctrl;
    import mem_access_pkg::*;

    localparam int DW = 16;
    localparam int AW = 8;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          req_valid;
    logic          req_write;
    logic [AW-1:0] req_address;
    logic [DW-1:0] req_wdata;
    logic          rsp_ready;
    logic [DW-1:0] ram_read_data;

    logic          req_ready, rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] ram_write_address, ram_read_address;
    logic          ram_write_enable, ram_read_enable;
    logic [DW-1:0] ram_write_data;
    logic [15:0]   store_count, load_count;

    logic          req_ready4, rsp_valid4;
    logic [DW-1:0] rsp_rdata4;
    logic [AW-1:0] ram_write_address4, ram_read_address4;
    logic          ram_write_enable4, ram_read_enable4;
    logic [DW-1:0] ram_write_data4;
    logic [3:0]    store_count4, load_count4;

    always #5 clock = ~clock;

    mem_access_ctrl #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .COUNT_WIDTH(16)) u_dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_address(req_address), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .ram_write_address(ram_write_address), .ram_write_enable(ram_write_enable),
        .ram_write_data(ram_write_data), .ram_read_address(ram_read_address),
        .ram_read_enable(ram_read_enable), .ram_read_data(ram_read_data),
        .store_count(store_count), .load_count(load_count)
    );

    mem_access_ctrl #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .COUNT_WIDTH(4)) u_dut4 (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready4), .req_write(req_write),
        .req_address(req_address), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata4),
        .ram_write_address(ram_write_address4), .ram_write_enable(ram_write_enable4),
        .ram_write_data(ram_write_data4), .ram_read_address(ram_read_address4),
        .ram_read_enable(ram_read_enable4), .ram_read_data(ram_read_data),
        .store_count(store_count4), .load_count(load_count4)
    );

    // Dual-port RAM with registered read, driven by the main instance.
    logic [DW-1:0] ram [256] = '{default: '0};
    always @(posedge clock) begin
        if (ram_write_enable) ram[ram_write_address] <= ram_write_data;
        if (ram_read_enable) ram_read_data <= ram[ram_read_address];
    end

    // Reference model state.
    logic [DW-1:0] ref_mem [256];
    int n_store;
    int n_load;
    int errors;
    int checks;

    function automatic logic [31:0] sat(input int n, input int mx);
        return (n > mx) ? mx : n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_counts(input string tag);
        check({tag, " store_count"}, 32'(store_count), sat(n_store, 65535));
        check({tag, " load_count"}, 32'(load_count), sat(n_load, 65535));
        check({tag, " store_count4"}, 32'(store_count4), sat(n_store, 15));
        check({tag, " load_count4"}, 32'(load_count4), sat(n_load, 15));
    endtask

    // Present a store at a negedge; leaves req_valid asserted for back-to-back use.
    task automatic do_store(input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid   = 1'b1;
        req_write   = 1'b1;
        req_address = a;
        req_wdata   = d;
        #1;
        check("store req_ready", 32'(req_ready), 1);
        check("store wr_en", 32'(ram_write_enable), 1);
        check("store rd_en", 32'(ram_read_enable), 0);
        check("store wr_addr", 32'(ram_write_address), 32'(a));
        check("store wr_data", 32'(ram_write_data), 32'(d));
        @(negedge clock);
        ref_mem[a] = d;
        n_store++;
        check_counts("store");
    endtask

    task automatic go_idle();
        req_valid = 1'b0;
        @(negedge clock);
    endtask

    // Full load transaction with the consumer stalling for 'hold' cycles.
    task automatic do_load(input logic [AW-1:0] a, input int hold);
        logic [DW-1:0] first;
        req_valid   = 1'b1;
        req_write   = 1'b0;
        req_address = a;
        #1;
        check("load req_ready", 32'(req_ready), 1);
        check("load rd_en", 32'(ram_read_enable), 1);
        check("load wr_en", 32'(ram_write_enable), 0);
        check("load rd_addr", 32'(ram_read_address), 32'(a));
        @(negedge clock);
        // Keep offering a store while busy; it must not be taken.
        req_write   = 1'b1;
        req_address = a + 8'd1;
        req_wdata   = 16'hDEAD;
        #1;
        check("wait rsp_valid", 32'(rsp_valid), 0);
        check("wait req_ready", 32'(req_ready), 0);
        check("wait wr_en", 32'(ram_write_enable), 0);
        @(negedge clock);
        check("resp rsp_valid", 32'(rsp_valid), 1);
        check("resp rsp_rdata", 32'(rsp_rdata), 32'(ref_mem[a]));
        first = rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            rsp_ready = 1'b0;
            @(negedge clock);
            check("hold rsp_valid", 32'(rsp_valid), 1);
            check("hold rsp_rdata", 32'(rsp_rdata), 32'(first));
            check("hold req_ready", 32'(req_ready), 0);
            check("hold wr_en", 32'(ram_write_enable), 0);
            check_counts("hold");
        end
        rsp_ready = 1'b1;
        #1;
        check("handshake wr_en", 32'(ram_write_enable), 0);
        @(negedge clock);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        n_load++;
        check("done rsp_valid", 32'(rsp_valid), 0);
        check("done req_ready", 32'(req_ready), 1);
        check_counts("done");
    endtask

    initial begin
        errors = 0;
        checks = 0;
        n_store = 0;
        n_load = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        reset_n     = 1'b0;
        req_valid   = 1'b1;
        req_write   = 1'b1;
        req_address = 8'h33;
        req_wdata   = 16'h1234;
        rsp_ready   = 1'b0;
        repeat (3) @(negedge clock);
        check("reset req_ready", 32'(req_ready), 0);
        check("reset rsp_valid", 32'(rsp_valid), 0);
        check("reset rsp_rdata", 32'(rsp_rdata), 0);
        check("reset wr_en", 32'(ram_write_enable), 0);
        check("reset rd_en", 32'(ram_read_enable), 0);
        check_counts("reset");
        req_valid = 1'b0;
        reset_n   = 1'b1;
        @(negedge clock);

        // Store then load the same word.
        do_store(8'h12, 16'h00A5);
        go_idle();
        do_load(8'h12, 0);
        check("first store_count", 32'(store_count), 1);
        check("first load_count", 32'(load_count), 1);

        // Back-to-back stores, then read them back in order.
        for (int i = 0; i < 4; i++) do_store(AW'(i), DW'(16'h1000 + i * 16'h0111));
        go_idle();
        for (int i = 0; i < 4; i++) do_load(AW'(i), 0);

        // Consumer stalls for 5 cycles.
        do_load(8'h02, 5);

        // Top address, then bottom address: no aliasing.
        do_store(8'hFF, 16'hFFFF);
        do_load(8'hFF, 1);
        do_load(8'h00, 0);

        // Store immediately followed by a load of the same address.
        do_store(8'h55, 16'hBEEF);
        do_load(8'h55, 0);

        // Reset while the load is waiting on RAM latency.
        req_valid   = 1'b1;
        req_write   = 1'b0;
        req_address = 8'h12;
        @(negedge clock);
        req_valid = 1'b0;
        #1;
        check("rdwait req_ready", 32'(req_ready), 0);
        reset_n = 1'b0;
        #1;
        check("midreset rsp_valid", 32'(rsp_valid), 0);
        check("midreset req_ready", 32'(req_ready), 0);
        @(negedge clock);
        reset_n = 1'b1;
        n_store = 0;
        n_load  = 0;
        for (int i = 0; i < 3; i++) begin
            rsp_ready = 1'b1;
            @(negedge clock);
            check("postreset rsp_valid", 32'(rsp_valid), 0);
            check("postreset req_ready", 32'(req_ready), 1);
            check_counts("postreset");
        end
        rsp_ready = 1'b0;

        // Twenty stores: the 4-bit counter pins at 4'hF.
        for (int i = 0; i < 20; i++) do_store(AW'(8'h40 + i), DW'($urandom));
        go_idle();
        check("sat store_count4", 32'(store_count4), 32'hF);
        check("sat store_count", 32'(store_count), 20);

        // Randomized mix of stores and loads against the model.
        for (int i = 0; i < 60; i++) begin
            logic [AW-1:0] a;
            a = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(8'h40, 8'h47));
            if ($urandom_range(0, 1) == 1) begin
                do_store(a, DW'($urandom));
                if ($urandom_range(0, 1) == 1) go_idle();
            end else begin
                do_load(a, int'($urandom_range(0, 3)));
            end
        end
        go_idle();
        check_counts("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
